mod_mul_877_seq: RTL and testbench

Sequential modular multiplier that computes dout_r = (din_a × din_b) mod P, with P = 877 by default. It builds the product one multiplier bit per cycle using interleaved (Blakley) shift-add-subtract, so no full-width product or Barrett constant is needed. It is the upstream producer side of the mod-877 reduction path: it turns operand pairs into residues for the Galois datapath. Valid/ready handshakes on input and output let it sit between streaming stages.

---
 rtl/mod_mul_877_seq.sv | 122 ++++++++++++
 tb/tb_mod_mul_877_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_877_seq.sv
// Sequential modular multiplier: dout_r = (din_a * din_b) mod P, built with
// interleaved (Blakley) shift-add-subtract, one multiplier bit per cycle.
module mod_mul_877_seq #(
  parameter int unsigned P = 877,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din_a,
  input  logic [W-1:0] din_b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] dout_r,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned AW = W + 2;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]  P_W  = W'(P);
  localparam logic [AW-1:0] P_1  = AW'(P);
  localparam logic [AW-1:0] P_2  = AW'(2 * P);
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_r, a_nxt;
  logic [W-1:0]  b_r, b_nxt;
  logic [W-1:0]  r, r_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  dout_nxt;
  logic          in_ready_nxt;
  logic          out_valid_nxt;
  logic [AW-1:0] t;
  logic [AW-1:0] t_red;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      r         <= '0;
      cnt       <= '0;
      dout_r    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      a_r       <= a_nxt;
      b_r       <= b_nxt;
      r         <= r_nxt;
      cnt       <= cnt_nxt;
      dout_r    <= dout_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state, iteration step and registered-output next values
  always_comb begin
    state_nxt     = state;
    a_nxt         = a_r;
    b_nxt         = b_r;
    r_nxt         = r;
    cnt_nxt       = cnt;
    dout_nxt      = dout_r;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;

    // t < 3P always, so at most two conditional subtractions bring it below P
    t = {1'b0, r, 1'b0} + (b_r[cnt] ? {2'b00, a_r} : '0);
    if (t >= P_2) begin
      t_red = t - P_2;
    end else if (t >= P_1) begin
      t_red = t - P_1;
    end else begin
      t_red = t;
    end

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_nxt        = (din_a >= P_W) ? (din_a - P_W) : din_a;
          b_nxt        = din_b;
          r_nxt        = '0;
          cnt_nxt      = CNT_TOP;
          in_ready_nxt = 1'b0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        r_nxt = t_red[W-1:0];
        if (cnt == '0) begin
          dout_nxt      = t_red[W-1:0];
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b1;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_mul_877_seq.sv
// Scoreboard bench for mod_mul_877_seq: accepts push (a*b)%P, a monitor pops
// and compares on every output handshake; directed cases plus random traffic.
module tb_mod_mul_877_seq;

  localparam int unsigned P = 877;
  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din_a = '0;
  logic [W-1:0] din_b = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dout_r;
  logic         out_valid;
  logic         out_ready;

  logic         ready_force = 1'b1;
  logic         rnd_ready = 1'b1;
  bit           stall_mode = 1'b0;

  typedef struct {
    int unsigned exp;
    int unsigned acc;
  } item_t;

  item_t       sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  bit          have_last = 1'b0;
  bit          gap_check = 1'b0;
  bit          prev_ov = 1'b0;
  int          last_dout = -1;

  mod_mul_877_seq #(.P(P), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_a    (din_a),
    .din_b    (din_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout_r   (dout_r),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  assign out_ready = stall_mode ? rnd_ready : ready_force;

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom);
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Abandoned operations produce nothing, so forget them on reset
  always @(negedge rst_n) begin
    sb.delete();
    have_last = 1'b0;
  end

  // Accept monitor: handshake visible at the negedge fires on the next posedge
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      if (gap_check && have_last)
        check("accept_gap", int'(cyc + 1 - last_acc), int'(W + 2));
      sb.push_back('{(int'(din_a) * int'(din_b)) % P, cyc + 1});
      last_acc  = cyc + 1;
      have_last = 1'b1;
    end
  end

  // Output monitor: latency on valid rise, value on handshake
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) fail("spurious_valid");
        else check("latency", int'(cyc - sb[0].acc), int'(W));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_result");
        end else begin
          it = sb.pop_front();
          check("dout", int'(dout_r), int'(it.exp));
          last_dout = int'(dout_r);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input int unsigned a, input int unsigned b, input bit hold);
    int  n;
    bit  seen;
    din_a    = W'(a);
    din_b    = W'(b);
    in_valid = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      fail("accept_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic directed(input int unsigned a, input int unsigned b, input int expected);
    issue(a, b, 1'b0);
    drain();
    check("directed_value", last_dout, expected);
  endtask

  initial begin
    int unsigned exp_bp;
    int          n;

    // Reset values, during and after reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(dout_r), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // 876*876: in_ready low for 11 cycles starting with the accept cycle
    issue(876, 876, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("busy_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    check("ready_again", int'(in_ready), 1);
    drain();
    check("directed_value", last_dout, 1);

    directed(1023, 1023, 268);
    directed(2, 439, 1);
    directed(0, 1023, 0);
    directed(877, 5, 0);
    directed(1023, 1, 146);
    directed(5, 0, 0);

    // Backpressure: result held, no accept while inputs wiggle
    ready_force = 1'b0;
    issue(123, 456, 1'b0);
    exp_bp = (123 * 456) % P;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail("bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      din_a    = W'($urandom);
      din_b    = W'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      check("bp_dout", int'(dout_r), int'(exp_bp));
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    @(negedge clk);
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    check("bp_queue", sb.size(), 0);
    ready_force = 1'b1;

    // Reset in BUSY cycle 5 abandons the operation
    issue(100, 200, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_dout", int'(dout_r), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    directed(3, 5, 15);

    // A sweep, back to back with in_valid held high
    have_last = 1'b0;
    gap_check = 1'b1;
    for (int a = 0; a < 1024; a++) issue(a, 876, 1'b1);
    in_valid = 1'b0;
    drain();
    gap_check = 1'b0;

    // Random operands with random downstream stalls
    stall_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      issue($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    stall_mode = 1'b0;

    check("final_queue", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
